// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared scancode constants and state encodings for the PS/2 key decoder
package ps2_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_PAUSE = 8'hE1;
   localparam logic [7:0] SC_OVR0  = 8'h00;
   localparam logic [7:0] SC_OVR1  = 8'hFF;
   localparam int         PAUSE_TAIL = 7;

   typedef enum logic [1:0] {
      PFX_NORMAL,
      PFX_EXT,
      PFX_BRK,
      PFX_EXT_BRK
   } pfx_state_e;

   typedef enum logic {
      FRM_IDLE,
      FRM_RECV
   } frm_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 pin conditioning and 11-bit device-to-host frame receiver
module ps2_frame_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_strobe,
   output logic       frame_err
);
   import ps2_pkg::*;

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          filt_q, filt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          fall;
   frm_state_e    state_q, state_d;
   logic [3:0]    bcnt_q, bcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    byte_q, byte_d;
   logic          strobe_q, strobe_d;
   logic          ferr_q, ferr_d;

   // The filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      fall   = 1'b0;
      if (clk_s2_q != filt_q) begin
         if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d = ~filt_q;
            fall   = filt_q;
         end else begin
            fcnt_d = fcnt_q + FW'(1);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      bcnt_d   = bcnt_q;
      shift_d  = shift_q;
      par_d    = par_q;
      tmo_d    = tmo_q;
      byte_d   = byte_q;
      strobe_d = 1'b0;
      ferr_d   = 1'b0;
      case (state_q)
         FRM_IDLE: begin
            tmo_d = '0;
            if (fall && !dat_s2_q) begin
               state_d = FRM_RECV;
               bcnt_d  = 4'd0;
            end
         end
         FRM_RECV: begin
            if (fall) begin
               tmo_d  = '0;
               bcnt_d = bcnt_q + 4'd1;
               if (bcnt_q < 4'd8) begin
                  shift_d = {dat_s2_q, shift_q[7:1]};
               end else if (bcnt_q == 4'd8) begin
                  par_d = dat_s2_q;
               end else begin
                  state_d = FRM_IDLE;
                  if ((^shift_q ^ par_q) && dat_s2_q) begin
                     byte_d   = shift_q;
                     strobe_d = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
               end
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d = FRM_IDLE;
               ferr_d  = 1'b1;
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: state_d = FRM_IDLE;
      endcase
   end

   // Pin synchronizers idle high so reset never manufactures a falling edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
         filt_q   <= 1'b1;
         fcnt_q   <= '0;
         state_q  <= FRM_IDLE;
         bcnt_q   <= 4'd0;
         shift_q  <= 8'h00;
         par_q    <= 1'b0;
         tmo_q    <= '0;
         byte_q   <= 8'h00;
         strobe_q <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         clk_s1_q <= ps2_clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= ps2_data;
         dat_s2_q <= dat_s1_q;
         filt_q   <= filt_d;
         fcnt_q   <= fcnt_d;
         state_q  <= state_d;
         bcnt_q   <= bcnt_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         tmo_q    <= tmo_d;
         byte_q   <= byte_d;
         strobe_q <= strobe_d;
         ferr_q   <= ferr_d;
      end
   end

   assign rx_byte     = byte_q;
   assign byte_strobe = strobe_q;
   assign frame_err   = ferr_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - strips make/break/extended/pause prefixes into clean key events
module ps2_key_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_data,
   output logic       key_extended,
   output logic       key_pressed,
   output logic       key_released,
   output logic       pause_pressed,
   output logic       frame_err,
   output logic       kbd_overrun
);
   import ps2_pkg::*;

   logic [7:0] rx_byte;
   logic       byte_strobe;

   pfx_state_e pfx_q, pfx_d;
   logic [2:0] skip_q, skip_d;
   logic [7:0] rx_q, rx_d;
   logic       ext_q, ext_d;
   logic       press_q, press_d;
   logic       rel_q, rel_d;
   logic       pause_q, pause_d;
   logic       ovr_q, ovr_d;

   ps2_frame_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_frame_rx (
      .clk         (clk),
      .reset       (reset),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .rx_byte     (rx_byte),
      .byte_strobe (byte_strobe),
      .frame_err   (frame_err)
   );

   always_comb begin
      pfx_d   = pfx_q;
      skip_d  = skip_q;
      rx_d    = rx_q;
      ext_d   = ext_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      pause_d = 1'b0;
      ovr_d   = 1'b0;
      if (byte_strobe) begin
         // The Pause tail carries no usable key information, so it is swallowed whole.
         if (skip_q != 3'd0) begin
            skip_d  = skip_q - 3'd1;
            pause_d = (skip_q == 3'd1);
         end else if (rx_byte == SC_PAUSE) begin
            skip_d = 3'(PAUSE_TAIL);
            pfx_d  = PFX_NORMAL;
         end else if (rx_byte == SC_EXT) begin
            pfx_d = PFX_EXT;
         end else if (rx_byte == SC_BRK) begin
            pfx_d = (pfx_q == PFX_EXT || pfx_q == PFX_EXT_BRK) ? PFX_EXT_BRK : PFX_BRK;
         end else if (rx_byte == SC_OVR0 || rx_byte == SC_OVR1) begin
            ovr_d = 1'b1;
            pfx_d = PFX_NORMAL;
         end else begin
            rx_d  = rx_byte;
            ext_d = (pfx_q == PFX_EXT || pfx_q == PFX_EXT_BRK);
            if (pfx_q == PFX_BRK || pfx_q == PFX_EXT_BRK) begin
               rel_d = 1'b1;
            end else begin
               press_d = 1'b1;
            end
            pfx_d = PFX_NORMAL;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pfx_q   <= PFX_NORMAL;
         skip_q  <= 3'd0;
         rx_q    <= 8'h00;
         ext_q   <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         pause_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         pfx_q   <= pfx_d;
         skip_q  <= skip_d;
         rx_q    <= rx_d;
         ext_q   <= ext_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         pause_q <= pause_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rx_data       = rx_q;
   assign key_extended  = ext_q;
   assign key_pressed   = press_q;
   assign key_released  = rel_q;
   assign pause_pressed = pause_q;
   assign kbd_overrun   = ovr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed scoreboard bench for ps2_key_decoder
module tb_ps2_key_decoder;

   localparam int FL = 8;
   localparam int TO = 200;
   localparam int K_PRESS = 0, K_REL = 1, K_PAUSE = 2, K_OVR = 3, K_FERR = 4;

   logic       clk = 1'b0;
   logic       reset, ps2_clk, ps2_data;
   logic [7:0] rx_data;
   logic       key_extended, key_pressed, key_released, pause_pressed, frame_err, kbd_overrun;

   ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clk           (clk),
      .reset         (reset),
      .ps2_clk       (ps2_clk),
      .ps2_data      (ps2_data),
      .rx_data       (rx_data),
      .key_extended  (key_extended),
      .key_pressed   (key_pressed),
      .key_released  (key_released),
      .pause_pressed (pause_pressed),
      .frame_err     (frame_err),
      .kbd_overrun   (kbd_overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         kind;
      logic [7:0] data;
      logic       ext;
      int         off;
   } ev_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad   = 0;
   int  last_fall = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push(input int kind, input logic [7:0] d, input logic e, input int off);
      exp_q.push_back(ev_t'{kind, d, e, off});
   endtask

   task automatic take(input int kind);
      ev_t e;
      total++;
      assert (exp_q.size() != 0) else begin
         bad++;
         $error("FAIL unexpected_event observed_kind=%0d expected=none cyc=%0d", kind, cyc);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("event_kind", kind, e.kind);
         chk($sformatf("latency_kind%0d", kind), cyc - last_fall, e.off);
         if (kind == K_PRESS || kind == K_REL) begin
            chk("rx_data", {24'h0, rx_data}, {24'h0, e.data});
            chk("key_extended", {31'h0, key_extended}, {31'h0, e.ext});
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (key_pressed && key_released)
            chk("press_release_overlap", {31'h0, key_pressed & key_released}, 32'h0);
         if (key_pressed)   take(K_PRESS);
         if (key_released)  take(K_REL);
         if (pause_pressed) take(K_PAUSE);
         if (kbd_overrun)   take(K_OVR);
         if (frame_err)     take(K_FERR);
      end
   end

   function automatic logic [10:0] mk(input logic [7:0] b, input bit badp);
      return {1'b1, (~^b) ^ badp, b, 1'b0};
   endfunction

   // Each bit: 30 cycles clock-high (optionally with a 3-cycle low glitch), 40 cycles low.
   task automatic send_bits(input logic [10:0] f, input int first, input int last, input bit glitch);
      for (int i = first; i <= last; i++) begin
         ps2_data = f[i];
         if (glitch) begin
            repeat (15) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (12) @(negedge clk);
         end else begin
            repeat (30) @(negedge clk);
         end
         ps2_clk   = 1'b0;
         last_fall = cyc;
         repeat (40) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(mk(b, 1'b0), 0, 10, 1'b0);
      repeat (20) @(negedge clk);
   endtask

   initial begin
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_rx_data", {24'h0, rx_data}, 32'h0);
      chk("rst_key_extended", {31'h0, key_extended}, 32'h0);
      chk("rst_key_pressed", {31'h0, key_pressed}, 32'h0);
      chk("rst_key_released", {31'h0, key_released}, 32'h0);
      chk("rst_pause_pressed", {31'h0, pause_pressed}, 32'h0);
      chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
      chk("rst_kbd_overrun", {31'h0, kbd_overrun}, 32'h0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      push(K_PRESS, 8'h1C, 1'b0, FL + 3);
      send_byte(8'h1C);

      push(K_REL, 8'h1C, 1'b0, FL + 3);
      send_byte(8'hF0);
      send_byte(8'h1C);

      push(K_PRESS, 8'h75, 1'b1, FL + 3);
      send_byte(8'hE0);
      send_byte(8'h75);
      push(K_REL, 8'h75, 1'b1, FL + 3);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);

      push(K_FERR, 8'h00, 1'b0, FL + 2);
      send_bits(mk(8'h1C, 1'b1), 0, 10, 1'b0);
      repeat (20) @(negedge clk);
      push(K_PRESS, 8'h45, 1'b0, FL + 3);
      send_byte(8'h45);

      push(K_FERR, 8'h00, 1'b0, FL + 2 + TO);
      send_bits(mk(8'h16, 1'b0), 0, 4, 1'b0);
      repeat (TO + 40) @(negedge clk);
      push(K_PRESS, 8'h16, 1'b0, FL + 3);
      send_byte(8'h16);

      push(K_PAUSE, 8'h00, 1'b0, FL + 3);
      send_byte(8'hE1);
      send_byte(8'h14);
      send_byte(8'h77);
      send_byte(8'hE1);
      send_byte(8'hF0);
      send_byte(8'h14);
      send_byte(8'hF0);
      send_byte(8'h77);

      push(K_PRESS, 8'h2B, 1'b0, FL + 3);
      send_bits(mk(8'h2B, 1'b0), 0, 10, 1'b1);
      repeat (20) @(negedge clk);

      push(K_OVR, 8'h00, 1'b0, FL + 3);
      send_byte(8'h00);
      push(K_OVR, 8'h00, 1'b0, FL + 3);
      send_byte(8'hFF);

      // Reset after start,b0,b1 of 0xFC: the remaining bits are all ones and must be ignored.
      send_bits(mk(8'hFC, 1'b0), 0, 2, 1'b0);
      reset = 1'b1;
      #1;
      chk("midrst_rx_data", {24'h0, rx_data}, 32'h0);
      chk("midrst_key_pressed", {31'h0, key_pressed}, 32'h0);
      chk("midrst_frame_err", {31'h0, frame_err}, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      send_bits(mk(8'hFC, 1'b0), 3, 10, 1'b0);
      repeat (TO + 40) @(negedge clk);
      chk("midrst_no_event_rx_data", {24'h0, rx_data}, 32'h0);
      push(K_PRESS, 8'h1C, 1'b0, FL + 3);
      send_byte(8'h1C);

      for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
